// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } pwm_state_e;

    // Consecutive agreeing samples required by the optional glitch filter.
    localparam int unsigned FiltDepth = 3;

endpackage

// File: rtl/sync_filter.sv
// pwm_in synchronizer with optional majority-free agreement filter.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to enable the FiltDepth-sample glitch filter.
module sync_filter
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic sig_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [FiltDepth-2:0] hist_q;
    logic [FiltDepth-1:0] window;
    logic                 filt_q;
    logic                 filt_d;

    // Window includes the live sample so the output moves FiltDepth-1 cycles late.
    assign window = {hist_q, sync_q[SYNC_STAGES-1]};

    always_comb begin
        filt_d = filt_q;
        if (&window) begin
            filt_d = 1'b1;
        end else if (~|window) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= window[FiltDepth-2:0];
            filt_q <= filt_d;
        end
    end

    assign sig_o = filt_d;
`else
    assign sig_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous pulse train.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic [CNT_W-1:0] timeout,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             lost
);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int unsigned FiltLat = FiltDepth - 1;
`else
    localparam int unsigned FiltLat = 0;
`endif
    // Cycles until sig_q reflects the real input after reset; edges before that are bogus.
    localparam int unsigned PrimeLen = SYNC_STAGES + 1 + FiltLat;

    logic                sig_s;
    logic                sig_q;
    logic [PrimeLen-1:0] prime_q;
    logic                primed;
    logic                rise;
    logic                fall;
    logic                timed_out;
    logic [CNT_W-1:0]    cnt_inc;

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;

    sync_filter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_filter (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .sig_i (pwm_in),
        .sig_o (sig_s)
    );

    assign primed    = prime_q[PrimeLen-1];
    assign rise      = primed & sig_s & ~sig_q;
    assign fall      = primed & ~sig_s & sig_q;
    assign timed_out = (timeout != '0) && (cnt_q >= timeout);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_lat_d     = hi_lat_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        lost_d       = lost_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (fall) begin
                    hi_lat_d = cnt_q;
                    cnt_d    = cnt_inc;
                    state_d  = StLow;
                end else if (timed_out) begin
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StLow: begin
                if (rise) begin
                    period_cnt_d = cnt_q;
                    high_cnt_d   = hi_lat_q;
                    valid_d      = 1'b1;
                    lost_d       = 1'b0;
                    cnt_d        = CNT_W'(1);
                    state_d      = StHigh;
                end else if (timed_out) begin
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sig_q        <= 1'b0;
            prime_q      <= '0;
            state_q      <= StIdle;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            sig_q        <= sig_s;
            prime_q      <= {prime_q[PrimeLen-2:0], 1'b1};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            lost_q       <= lost_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture (CNT_W=8 build); glitch case runs only with the filter macro.
module tb_pwm_capture;

    localparam int unsigned CntW = 8;

    typedef struct packed {
        logic [CntW-1:0] hi;
        logic [CntW-1:0] per;
    } exp_t;

    logic            clk_in;
    logic            rst_n;
    logic            pwm_in;
    logic [CntW-1:0] timeout;
    logic [CntW-1:0] high_cnt;
    logic [CntW-1:0] period_cnt;
    logic            valid;
    logic            lost;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    // Reference model of what the capture FSM should have seen.
    int   now;
    int   rise_t;
    int   hi_len;
    bit   in_high;
    bit   in_low;
    logic [CntW-1:0] last_hi;
    logic [CntW-1:0] last_per;

    int mcyc;
    int last_valid_cyc;
    int exp_gap;

    pwm_capture #(
        .CNT_W      (CntW),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .timeout   (timeout),
        .high_cnt  (high_cnt),
        .period_cnt(period_cnt),
        .valid     (valid),
        .lost      (lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CntW-1:0] sat(input int v);
        logic [31:0] w;
        w = v;
        return (v > 255) ? 8'd255 : w[CntW-1:0];
    endfunction

    // Drive pwm_in for n cycles, updating the model on clean edges.
    task automatic drive(input logic v, input int n);
        exp_t e;
        if (v && !pwm_in) begin
            if (in_low) begin
                e.hi     = sat(hi_len);
                e.per    = sat(now - rise_t);
                last_hi  = e.hi;
                last_per = e.per;
                sb_q.push_back(e);
            end
            rise_t  = now;
            in_high = 1'b1;
            in_low  = 1'b0;
        end else if (!v && pwm_in && in_high) begin
            hi_len  = now - rise_t;
            in_high = 1'b0;
            in_low  = 1'b1;
        end
        pwm_in = v;
        repeat (n) begin
            @(negedge clk_in);
            now++;
        end
    endtask

    // Drive without touching the model (glitches the filter must swallow).
    task automatic drive_raw(input logic v, input int n);
        pwm_in = v;
        repeat (n) begin
            @(negedge clk_in);
            now++;
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        mcyc++;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("high_cnt", 32'(high_cnt), 32'(e.hi));
                check_val("period_cnt", 32'(period_cnt), 32'(e.per));
                if (exp_gap != 0) begin
                    check_val("valid_gap", 32'(mcyc - last_valid_cyc), 32'(exp_gap));
                end
            end
            last_valid_cyc = mcyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        now      = 0;
        rise_t   = 0;
        hi_len   = 0;
        in_high  = 1'b0;
        in_low   = 1'b0;
        exp_gap  = 0;
        rst_n    = 1'b0;
        pwm_in   = 1'b0;
        timeout  = '0;
        repeat (2) @(negedge clk_in);
        check_val("rst_high_cnt", 32'(high_cnt), 32'd0);
        check_val("rst_period_cnt", 32'(period_cnt), 32'd0);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 10);

        // Periodic 10/30 train.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end

        // Divide-by-6 clock: valid every 6 cycles once settled.
        for (int i = 0; i < 6; i++) begin
            if (i == 2) exp_gap = 6;
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        exp_gap = 0;

        // Reset in the middle of a high phase.
        drive(1'b1, 5);
        rst_n = 1'b0;
        in_high = 1'b0;
        in_low  = 1'b0;
        #1;
        check_val("midrst_high_cnt", 32'(high_cnt), 32'd0);
        check_val("midrst_period_cnt", 32'(period_cnt), 32'd0);
        check_val("midrst_valid", 32'(valid), 32'd0);
        check_val("midrst_lost", 32'(lost), 32'd0);
        drive(1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 20);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end

        // Timeout while stuck high.
        timeout = 8'd100;
        drive(1'b1, 95);
        check_val("lost_before_timeout", 32'(lost), 32'd0);
        drive(1'b1, 15);
        in_high = 1'b0;
        in_low  = 1'b0;
        check_val("lost_after_timeout", 32'(lost), 32'd1);
        check_val("to_high_cnt_kept", 32'(high_cnt), 32'(last_hi));
        check_val("to_period_cnt_kept", 32'(period_cnt), 32'(last_per));
        drive(1'b0, 20);
        drive(1'b1, 10);
        drive(1'b0, 30);
        drive(1'b1, 10);
        timeout = '0;
        check_val("lost_cleared", 32'(lost), 32'd0);

        // Saturation with timeout disabled.
        drive(1'b0, 300);
        check_val("sat_no_lost", 32'(lost), 32'd0);
        drive(1'b1, 10);
        drive(1'b0, 30);
        drive(1'b1, 10);
        drive(1'b0, 30);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        // 20/20 signal with 1- and 2-cycle glitches the filter must drop.
        drive(1'b1, 8);
        drive_raw(1'b0, 1);
        drive_raw(1'b1, 11);
        drive(1'b0, 8);
        drive_raw(1'b1, 2);
        drive_raw(1'b0, 10);
        drive(1'b1, 8);
        drive_raw(1'b0, 2);
        drive_raw(1'b1, 10);
        drive(1'b0, 20);
        drive(1'b1, 10);
        drive(1'b0, 20);
`endif

        drive(1'b0, 20);
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all count ports.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (min 2): flops in the pwm_in synchronizer.
REQ-003 SHALL have port clk_in  input  1: sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in  input  1: asynchronous pulse train to measure, e.g. a clock divider or servo PWM output.
REQ-006 SHALL have port timeout  input  CNT_W: max cycles without an edge; 0 disables the timeout.
REQ-007 SHALL have port high_cnt  output  CNT_W: last measured high time, in clk_in cycles.
REQ-008 SHALL have port period_cnt  output  CNT_W: last measured rising-to-rising period, in clk_in cycles.
REQ-009 SHALL have port valid  output  1: single-cycle strobe when high_cnt/period_cnt update.
REQ-010 SHALL have port lost  output  1: sticky flag set when a timeout occurs.

Function
REQ-011 SHALL sample pwm_in through SYNC_STAGES flops, then edge-detect against one more registered sample (sig_q).
REQ-012 SHALL implement FSM IDLE -> HIGH -> LOW -> HIGH... with IDLE left only on a detected rising edge.
REQ-013 SHALL, on a rising edge in IDLE, load run counter to 1 and enter HIGH with no output update.
REQ-014 SHALL increment run counter every cycle in HIGH and LOW and latch high time on the falling edge (value = cycles from rise detect to fall detect), entering LOW.
REQ-015 SHALL, on a rising edge in LOW, write period_cnt = cycles since previous rise, write high_cnt = latched high time, pulse valid for 1 cycle on the following cycle, reload counter to 1 and enter HIGH.
REQ-016 SHALL saturate the run counter at 2^CNT_W-1; no wrap-around.
REQ-017 SHALL, when timeout != 0 and the run counter reaches timeout in HIGH or LOW, enter IDLE, set lost, and leave high_cnt/period_cnt unchanged.
REQ-018 SHALL clear lost on the cycle valid asserts; timeout and edge in the same cycle: edge wins, lost not set.
REQ-019 SHALL ignore a falling edge seen in IDLE or LOW and a rising edge seen in HIGH; neither is possible after synchronization except via the timeout path.
REQ-020 SHALL hold high_cnt and period_cnt stable between valid strobes.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear synchronizer flops, sig_q, counters, high_cnt, period_cnt, valid and lost to 0 and put the FSM in IDLE.
REQ-022 SHALL, after reset release mid-pulse, make its first measurement only after a clean rising edge.

Configuration
REQ-023 SHALL, with PWM_CAPTURE_GLITCH_FILTER_EN defined, pass the synchronized input through a 3-sample filter that changes only when 3 consecutive samples agree, adding 2 cycles of edge latency (counts unchanged for pulses >= 3 cycles; pulses < 3 cycles are discarded).
REQ-024 SHALL, without the macro, feed the synchronizer output straight to the edge detector.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, HIGH, LOW) and the filter depth constant in shared package pwm_pkg.
REQ-026 SHALL implement the synchronizer (plus the optional filter) as sub-module sync_filter; all else stays in pwm_capture.

Verification
REQ-027 Periodic input, high 10 / low 30 cycles -> after second rise: valid 1 cycle, high_cnt=10, period_cnt=40, repeating every 40 cycles.
REQ-028 Input held high after one rise, timeout=100 -> lost=1 about 100 cycles after the rise, FSM IDLE, counts unchanged; next full pulse clears lost.
REQ-029 rst_n low mid-HIGH for 3 cycles -> all outputs 0 immediately; no valid until rise, fall, rise have completed.
REQ-030 timeout=0, input constant for 2^CNT_W+5 cycles (CNT_W=8 build) -> run counter saturates at 255, no lost, then period_cnt=255 on the next rise.
REQ-031 With PWM_CAPTURE_GLITCH_FILTER_EN, 1-cycle and 2-cycle glitches inside a 20/20 signal -> high_cnt=20, period_cnt=40, no extra valid.
REQ-032 Input driven by a divide-by-6 clock divider -> high_cnt=3, period_cnt=6, valid every 6 cycles.
